// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker state encoding and polynomial-name to LFSR-length lookup.
// Polynomial names are 6-character packed strings ("LFSR6", "LFSR7", "LFSR15", "LFSR22").
package prbs_pkg;

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} prbs_chk_state_t;

    typedef logic [47:0] lfsr_name_t;

    function automatic int lfsr_len(input lfsr_name_t name);
        case (name)
            lfsr_name_t'("LFSR6"):  return 6;
            lfsr_name_t'("LFSR7"):  return 7;
            lfsr_name_t'("LFSR15"): return 15;
            default:                return 22;
        endcase
    endfunction

endpackage

// File: rtl/prbs2_checker_sat_counter.sv
// Saturating up-counter with a 0..3 increment per enabled cycle; clear has priority over counting.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [1:0]   inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W:0] sum;

    assign sum = {1'b0, cnt} + {{(W - 1){1'b0}}, inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= sum[W] ? '1 : sum[W-1:0];
        end
    end

endmodule

// File: rtl/prbs2_checker.sv
// Self-synchronising checker for the 2-bit-per-beat PRBS stream (s[n] = s[n-N] ^ s[n-N+1]).
// Define PRBS_CHK_BEATCNT_EN to add beat_cnt_o, the count of valid beats seen while locked.
module prbs2_checker
    import prbs_pkg::*;
#(
    parameter lfsr_name_t LFSR       = "LFSR22",
    parameter int         LOCK_BEATS = 16,
    parameter int         LOSS_BEATS = 4,
    parameter int         ERR_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [1:0]       data_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_cnt_o
`ifdef PRBS_CHK_BEATCNT_EN
    ,
    output logic [47:0]      beat_cnt_o
`endif
);

    localparam int         N      = lfsr_len(LFSR);
    localparam int         RUN_W  = $clog2(LOCK_BEATS + 1);
    localparam int         LOSS_W = $clog2(LOSS_BEATS + 1);
    localparam logic [5:0] N_BITS = 6'(N);

    prbs_chk_state_t   state;
    logic [N-1:0]      hist;
    logic [5:0]        fill;
    logic [RUN_W-1:0]  clean_run;
    logic [LOSS_W-1:0] loss_run;

    logic              valid_q;
    logic [1:0]        data_q;
    logic              clear_q;

    // Input stage: a beat and any clear issued with it travel together, so clear wins on that edge.
    // NOTE: every register in this design uses <= so all flops sample pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= 2'b00;
            clear_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
            data_q  <= data_i;
            clear_q <= clear_i;
        end
    end

    logic [1:0]        pred;
    logic [1:0]        diff;
    logic [1:0]        beat_err;
    logic [N-1:0]      hist_rx;
    logic [N-1:0]      hist_pred;
    logic [5:0]        fill_sum;
    logic [5:0]        fill_inc;
    logic [RUN_W-1:0]  clean_inc;
    logic [LOSS_W-1:0] loss_inc;
    logic              lock_count_en;

    assign pred          = {hist[N-1] ^ hist[N-2], hist[N-2] ^ hist[N-3]};
    assign diff          = data_q ^ pred;
    assign beat_err      = {1'b0, diff[1]} + {1'b0, diff[0]};
    assign hist_rx       = {hist[N-3:0], data_q};
    assign hist_pred     = {hist[N-3:0], pred};
    assign fill_sum      = fill + 6'd2;
    assign fill_inc      = (fill_sum > N_BITS) ? N_BITS : fill_sum;
    assign clean_inc     = clean_run + RUN_W'(1);
    assign loss_inc      = loss_run + LOSS_W'(1);
    assign lock_count_en = valid_q && (state == LOCKED);

    // NOTE: hist is reset too: the all-zero test must never see X after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= HUNT;
            hist      <= '0;
            fill      <= '0;
            clean_run <= '0;
            loss_run  <= '0;
            locked_o  <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            err_o <= 1'b0;
            if (valid_q) begin
                case (state)
                    HUNT: begin
                        hist <= hist_rx;
                        fill <= fill_inc;
                        if (fill_inc >= N_BITS && hist_rx != '0) begin
                            state     <= CHECK;
                            clean_run <= '0;
                        end
                    end
                    CHECK: begin
                        hist <= hist_rx;
                        // A dead (all-zero) link predicts itself perfectly; refuse it before anything else.
                        if (hist_rx == '0) begin
                            state     <= HUNT;
                            fill      <= '0;
                            clean_run <= '0;
                        end else if (beat_err != 2'd0) begin
                            state     <= HUNT;
                            fill      <= N_BITS;
                            clean_run <= '0;
                        end else if (clean_inc == RUN_W'(LOCK_BEATS)) begin
                            state     <= LOCKED;
                            locked_o  <= 1'b1;
                            clean_run <= '0;
                            loss_run  <= '0;
                        end else begin
                            clean_run <= clean_inc;
                        end
                    end
                    LOCKED: begin
                        // Freewheel on the prediction so one corrupted bit is counted exactly once.
                        hist  <= hist_pred;
                        err_o <= (beat_err != 2'd0);
                        if (beat_err == 2'd0) begin
                            loss_run <= '0;
                        end else if (loss_inc == LOSS_W'(LOSS_BEATS)) begin
                            state    <= HUNT;
                            fill     <= '0;
                            loss_run <= '0;
                            locked_o <= 1'b0;
                        end else begin
                            loss_run <= loss_inc;
                        end
                    end
                    default: begin
                        state    <= HUNT;
                        fill     <= '0;
                        locked_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .en    (lock_count_en),
        .inc   (beat_err),
        .clr   (clear_q),
        .cnt   (err_cnt_o)
    );

`ifdef PRBS_CHK_BEATCNT_EN
    sat_counter #(.W(48)) u_beat_cnt (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .en    (lock_count_en),
        .inc   (2'd1),
        .clr   (clear_q),
        .cnt   (beat_cnt_o)
    );
`endif

endmodule

// File: tb/tb_prbs2_checker.sv
// Scoreboard bench for prbs2_checker (LFSR7, ERR_W=4): a driver queues expected outputs per beat,
// a monitor compares them two edges later, when the beat's result is due.
module tb_prbs2_checker;
    import prbs_pkg::*;

    localparam int ERR_W   = 4;
    localparam int LOCK_AT = 20;  // ceil(7/2) fill beats + 16 clean beats

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             valid_i;
    logic [1:0]       data_i;
    logic             clear_i;
    logic             locked_o;
    logic             err_o;
    logic [ERR_W-1:0] err_cnt_o;
`ifdef PRBS_CHK_BEATCNT_EN
    logic [47:0]      beat_cnt_o;
`endif

    typedef struct {
        int         due;
        string      name;
        logic [5:0] exp;
    } item_t;

    item_t      sb[$];
    int         cyc     = 0;
    int         n_pass  = 0;
    int         n_total = 0;
    logic [6:0] gen     = 7'h01;

    prbs2_checker #(
        .LFSR       (lfsr_name_t'("LFSR7")),
        .LOCK_BEATS (16),
        .LOSS_BEATS (4),
        .ERR_W      (ERR_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .clear_i    (clear_i),
        .locked_o   (locked_o),
        .err_o      (err_o),
        .err_cnt_o  (err_cnt_o)
`ifdef PRBS_CHK_BEATCNT_EN
        ,
        .beat_cnt_o (beat_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got lock=%0b err=%0b cnt=%0d, want lock=%0b err=%0b cnt=%0d",
                     name, act[5], act[4], act[3:0], exp[5], exp[4], exp[3:0]);
        end
    endtask

    function automatic logic [5:0] pack3(input logic lk, input logic er, input int cn);
        return {lk, er, 4'(cn)};
    endfunction

    // Reference generator, advanced one bit at a time; the first bit out is the older one.
    task automatic next_pair(output logic [1:0] d);
        logic nb;
        d = 2'b00;
        for (int i = 0; i < 2; i++) begin
            nb  = gen[6] ^ gen[5];
            gen = {gen[5:0], nb};
            d   = {d[0], nb};
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] d, input logic clr,
                         input string nm, input logic chk, input logic [5:0] e);
        @(negedge clk_i);
        valid_i = v;
        data_i  = d;
        clear_i = clr;
        if (chk) sb.push_back('{due: cyc + 2, name: nm, exp: e});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 1'b0, "idle", 1'b0, 6'd0);
    endtask

    initial begin
        item_t it;
        forever begin
            @(posedge clk_i);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                it = sb.pop_front();
                check(it.name, {locked_o, err_o, err_cnt_o}, it.exp);
            end
        end
    end

    initial begin
        logic [1:0] d;
        int         c;
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        data_i  = 2'b00;
        clear_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset", {locked_o, err_o, err_cnt_o}, 6'd0);
        rst_ni = 1'b1;

        for (int i = 0; i < 200; i++) drive(1'b1, 2'b00, 1'b0, "stuck_zero", 1'b1, pack3(0, 0, 0));
        idle(3);
        @(negedge clk_i) rst_ni = 1'b0;
        @(negedge clk_i) rst_ni = 1'b1;

        gen = 7'h01;
        for (int k = 1; k <= 1040; k++) begin
            next_pair(d);
            drive(1'b1, d, 1'b0, "acquire", 1'b1, pack3(k >= LOCK_AT, 0, 0));
        end

        next_pair(d);
        drive(1'b1, d ^ 2'b01, 1'b0, "flip_bit0", 1'b1, pack3(1, 1, 1));
        for (int k = 0; k < 20; k++) begin
            next_pair(d);
            drive(1'b1, d, 1'b0, "after_flip", 1'b1, pack3(1, 0, 1));
        end

        drive(1'b0, 2'b00, 1'b1, "clear_idle", 1'b1, pack3(1, 0, 0));
        for (int j = 1; j <= 4; j++) begin
            next_pair(d);
            drive(1'b1, ~d, 1'b0, "invert_loss", 1'b1, pack3(j < 4, 1, 2 * j));
        end
        for (int k = 1; k <= 30; k++) begin
            next_pair(d);
            drive(1'b1, d, 1'b0, "relock", 1'b1, pack3(k >= LOCK_AT, 0, 8));
        end

        drive(1'b0, 2'b00, 1'b1, "clear_idle2", 1'b1, pack3(1, 0, 0));
        for (int j = 1; j <= 10; j++) begin
            c = (2 * j > 15) ? 15 : 2 * j;
            next_pair(d);
            drive(1'b1, ~d, 1'b0, "sat_err", 1'b1, pack3(1, 1, c));
            next_pair(d);
            drive(1'b1, d, 1'b0, "sat_clean", 1'b1, pack3(1, 0, c));
        end
        next_pair(d);
        drive(1'b1, ~d, 1'b1, "clear_wins", 1'b1, pack3(1, 1, 0));
        next_pair(d);
        drive(1'b1, ~d, 1'b0, "post_clear_err", 1'b1, pack3(1, 1, 2));
        next_pair(d);
        drive(1'b1, d, 1'b0, "post_clear_ok", 1'b1, pack3(1, 0, 2));
        idle(3);

        @(negedge clk_i) rst_ni = 1'b0;
        #1 check("async_reset", {locked_o, err_o, err_cnt_o}, 6'd0);
        @(negedge clk_i) rst_ni = 1'b1;

        for (int k = 1; k <= 300; k++) begin
            next_pair(d);
            drive(1'b1, d, 1'b0, "toggle_valid", 1'b1, pack3(k >= LOCK_AT, 0, 0));
            drive(1'b0, 2'b11, 1'b0, "toggle_gap", 1'b1, pack3(k >= LOCK_AT, 0, 0));
        end

        for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk_i);
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
